// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// Serial-to-parallel UART receive stage, 8N1, LSB first. The asynchronous line
// is brought into the clock domain with a two-flop synchroniser. A high-to-low
// transition on the synchronised line opens a frame. The start bit is
// re-checked at mid-bit, and each data bit and the stop bit are sampled at
// mid-bit. A good frame produces a one-cycle o_DV pulse with the byte on
// o_Byte. A low stop bit produces a one-cycle o_Frame_Err pulse instead.
//
// Parameters
//   FREQUENCY      clk cycles per bit (4..255); must match the transmitter
//
// Ports
//   clk            system clock, rising edge
//   i_Rst_n        asynchronous active-low reset
//   i_Serial_Data  asynchronous serial line, idle high
//   o_DV           one-cycle pulse, o_Byte carries a new byte
//   o_Byte         last correctly received byte
//   o_Sig_Active   high while a frame is in flight (START..STOP)
//   o_Frame_Err    one-cycle pulse, stop bit was sampled low
// -----------------------------------------------------------------------------
module uart_receiver #(
  parameter int unsigned FREQUENCY = 87
) (
  input  logic       clk,
  input  logic       i_Rst_n,
  input  logic       i_Serial_Data,
  output logic       o_DV,
  output logic [7:0] o_Byte,
  output logic       o_Sig_Active,
  output logic       o_Frame_Err
);

  localparam int unsigned CNT_W    = 8;
  localparam int unsigned IDX_W    = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned HALF_BIT = (FREQUENCY - 1) / 2;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(HALF_BIT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FREQUENCY - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(7);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_DATA    = 3'd2,
    ST_STOP    = 3'd3,
    ST_CLEANUP = 3'd4
  } state_t;

  // Synchroniser and edge-detect flops.
  logic sync1_q;
  logic sync2_q;
  logic prev_q;
  logic rx_s;

  // Frame state.
  state_t              state_q,  state_d;
  logic [CNT_W-1:0]    cnt_q,    cnt_d;
  logic [IDX_W-1:0]    idx_q,    idx_d;
  logic [BYTE_W-1:0]   shift_q,  shift_d;
  logic [BYTE_W-1:0]   byte_q,   byte_d;
  logic                dv_q,     dv_d;
  logic                ferr_q,   ferr_d;
  logic                active_q, active_d;

  assign rx_s = sync2_q;

  // Two-flop synchroniser plus one-cycle delayed copy; preset high so a
  // reset release never looks like a falling edge on an idle line.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_Serial_Data;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      active_q <= active_d;
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    active_d = active_q;

    case (state_q)
      ST_IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        // Only a genuine high-to-low transition opens a frame; a line that
        // stays low (break) is ignored until it has returned high.
        if (prev_q && !rx_s) begin
          state_d  = ST_START;
          active_d = 1'b1;
        end
      end

      ST_START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d = '0;
          if (!rx_s) begin
            state_d = ST_DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d  = ST_IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = ST_STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_STOP: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d    = '0;
          state_d  = ST_CLEANUP;
          active_d = 1'b0;
          if (rx_s) begin
            byte_d = shift_q;
            dv_d   = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_CLEANUP: begin
        // dv_d/ferr_d already default low, closing the one-cycle pulse.
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_DV         = dv_q;
  assign o_Byte       = byte_q;
  assign o_Sig_Active = active_q;
  assign o_Frame_Err  = ferr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Directed bench for uart_receiver at FREQUENCY=87. The bench plays the
// transmitter on the serial line. Each expected output event (byte or framing
// error) is queued when the stimulus is issued. A monitor forked from the main
// process pops and compares whenever o_DV or o_Frame_Err pulses.
// -----------------------------------------------------------------------------
module tb_uart_receiver;

  localparam int unsigned FREQ    = 87;
  localparam int unsigned DV_LAT  = 830;  // 2 + 1 + 43 + 9*87 + 1
  localparam int unsigned ACT_LEN = 827;  // cycles spent in START+DATA+STOP

  typedef struct packed {
    logic       ferr;
    logic [7:0] data;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       serial;
  logic       o_dv;
  logic [7:0] o_byte;
  logic       o_active;
  logic       o_ferr;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   fall_cyc = 0;
  int   act_cnt = 0;
  exp_t exp_q[$];
  logic [7:0] abort_b;

  uart_receiver #(.FREQUENCY(FREQ)) dut (
    .clk          (clk),
    .i_Rst_n      (rst_n),
    .i_Serial_Data(serial),
    .o_DV         (o_dv),
    .o_Byte       (o_byte),
    .o_Sig_Active (o_active),
    .o_Frame_Err  (o_ferr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_t e;
    e.ferr = 1'b0;
    e.data = b;
    exp_q.push_back(e);
  endtask

  // A framing error carries the byte o_Byte must still hold at that moment.
  task automatic push_ferr(input logic [7:0] held);
    exp_t e;
    e.ferr = 1'b1;
    e.data = held;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] b, input int per, input logic stop);
    serial   = 1'b0;
    fall_cyc = cyc;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      serial = b[i];
      repeat (per) @(negedge clk);
    end
    serial = stop;
    repeat (per) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Output monitor: consumes the expectation queue on every pulse.
  task automatic monitor_loop();
    exp_t e;
    int   lat;
    forever begin
      @(negedge clk);
      if (o_active) act_cnt++;
      if (rst_n && (o_dv || o_ferr)) begin
        if (o_dv && o_ferr) begin
          checks++;
          errors++;
          $display("FAIL pulse_excl: o_DV=1 o_Frame_Err=1 expected only one");
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse: dv=%0b ferr=%0b byte=%0h expected no pulse",
                   o_dv, o_ferr, o_byte);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind(ferr)", int'(o_ferr), int'(e.ferr));
          chk("event_byte", int'(o_byte), int'(e.data));
          if (o_dv) begin
            lat = cyc - fall_cyc;
            checks++;
            if (lat < DV_LAT - 1 || lat > DV_LAT + 1) begin
              errors++;
              $display("FAIL dv_latency: got %0d expected %0d +/-1", lat, DV_LAT);
            end
          end
        end
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    serial = 1'b1;
    fork
      monitor_loop();
    join_none

    // Reset values.
    repeat (5) @(negedge clk);
    chk("rst_dv", int'(o_dv), 0);
    chk("rst_byte", int'(o_byte), 0);
    chk("rst_active", int'(o_active), 0);
    chk("rst_ferr", int'(o_ferr), 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Single frame A5 and o_Sig_Active width.
    push_byte(8'hA5);
    act_cnt = 0;
    send_frame(8'hA5, FREQ, 1'b1);
    wait_drain("drain_a5");
    repeat (20) @(negedge clk);
    chk("active_len_a5", act_cnt, ACT_LEN);
    chk("active_idle_a5", int'(o_active), 0);

    // Back-to-back frames.
    push_byte(8'h00);
    push_byte(8'hFF);
    push_byte(8'h3C);
    send_frame(8'h00, FREQ, 1'b1);
    send_frame(8'hFF, FREQ, 1'b1);
    send_frame(8'h3C, FREQ, 1'b1);
    wait_drain("drain_b2b");
    repeat (20) @(negedge clk);

    // Short low glitch is rejected.
    serial = 1'b0;
    repeat (20) @(negedge clk);
    serial = 1'b1;
    repeat (200) @(negedge clk);
    chk("glitch_byte", int'(o_byte), 8'h3C);
    chk("glitch_active", int'(o_active), 0);

    // Framing error followed by a held-low break.
    push_ferr(8'h3C);
    send_frame(8'h55, FREQ, 1'b0);
    repeat (5 * FREQ) @(negedge clk);
    chk("break_active", int'(o_active), 0);
    serial = 1'b1;
    repeat (300) @(negedge clk);
    wait_drain("drain_ferr");
    chk("ferr_byte_kept", int'(o_byte), 8'h3C);
    push_byte(8'h81);
    send_frame(8'h81, FREQ, 1'b1);
    wait_drain("drain_81");
    repeat (20) @(negedge clk);

    // Reset during data bit 4 of C3; the aborted frame must produce nothing.
    abort_b  = 8'hC3;
    serial   = 1'b0;
    fall_cyc = cyc;
    repeat (FREQ) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      serial = abort_b[i];
      repeat (FREQ) @(negedge clk);
    end
    serial = abort_b[4];
    repeat (40) @(negedge clk);
    rst_n  = 1'b0;
    serial = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_dv", int'(o_dv), 0);
    chk("midrst_byte", int'(o_byte), 0);
    chk("midrst_active", int'(o_active), 0);
    chk("midrst_ferr", int'(o_ferr), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (1000) @(negedge clk);
    push_byte(8'h7E);
    send_frame(8'h7E, FREQ, 1'b1);
    wait_drain("drain_7e");
    repeat (20) @(negedge clk);

    // Bit-period tolerance.
    push_byte(8'h96);
    send_frame(8'h96, 84, 1'b1);
    wait_drain("drain_96_slow_rx");
    repeat (50) @(negedge clk);
    push_byte(8'h96);
    send_frame(8'h96, 90, 1'b1);
    wait_drain("drain_96_fast_rx");
    repeat (200) @(negedge clk);
    chk("final_byte", int'(o_byte), 8'h96);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
